// File: rtl/tow_led_monitor_pkg.sv
// Shared definitions for the tow LED monitor: LED patterns, FSM states,
// error codes and the pattern decoder.
package tow_led_monitor_pkg;

   localparam logic [6:0] LED_ALLON = 7'b1111111;
   localparam logic [6:0] LED_DARK  = 7'b0000000;
   localparam logic [6:0] LED_WL    = 7'b1110000;
   localparam logic [6:0] LED_WR    = 7'b0000111;
   localparam logic [6:0] P_L3      = 7'b1000000;
   localparam logic [6:0] P_L2      = 7'b0100000;
   localparam logic [6:0] P_L1      = 7'b0010000;
   localparam logic [6:0] P_N       = 7'b0001000;
   localparam logic [6:0] P_R1      = 7'b0000100;
   localparam logic [6:0] P_R2      = 7'b0000010;
   localparam logic [6:0] P_R3      = 7'b0000001;

   // Rope positions as 3-bit two's complement.
   localparam logic [2:0] POS_L3 = 3'b101;
   localparam logic [2:0] POS_N  = 3'b000;
   localparam logic [2:0] POS_R3 = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE, ST_GRST, ST_DARK, ST_POS, ST_WIN, ST_ERR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_UNKNOWN = 2'd1,
      ERR_JUMP    = 2'd2,
      ERR_WIN     = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      PK_ALLON, PK_DARK, PK_POS, PK_WL, PK_WR, PK_BAD
   } pat_kind_e;

   typedef struct packed {
      pat_kind_e  kind;
      logic [2:0] pos;   // valid only when kind == PK_POS
   } pat_t;

   // Classify an LED pattern and recover the rope position from a one-hot.
   function automatic pat_t decode_led(input logic [6:0] led);
      pat_t p;
      p.kind = PK_POS;
      p.pos  = POS_N;
      case (led)
         LED_ALLON: p.kind = PK_ALLON;
         LED_DARK:  p.kind = PK_DARK;
         LED_WL:    p.kind = PK_WL;
         LED_WR:    p.kind = PK_WR;
         P_L3:      p.pos  = 3'b101;
         P_L2:      p.pos  = 3'b110;
         P_L1:      p.pos  = 3'b111;
         P_N:       p.pos  = 3'b000;
         P_R1:      p.pos  = 3'b001;
         P_R2:      p.pos  = 3'b010;
         P_R3:      p.pos  = 3'b011;
         default:   p.kind = PK_BAD;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/tow_led_monitor_filter.sv
// Stability filter for the LED bus: samples every edge and emits a one-cycle
// accept once STABLE_CYC identical samples differ from the last accepted pattern.
module tow_led_filter #(
   parameter int STABLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] i_led,
   output logic [6:0] o_pat,
   output logic       o_accept
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   logic [6:0]    r_sample;
   logic [6:0]    r_pat;
   logic          r_held;
   logic          r_accept;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_fire;

   // Run length of the incoming sample, saturating at STABLE_CYC.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_cnt_nxt = r_cnt;
      if (r_cnt == '0 || i_led != r_sample)
         w_cnt_nxt = CW'(1);
      else if (r_cnt != CW'(STABLE_CYC))
         w_cnt_nxt = r_cnt + CW'(1);
      w_fire = (w_cnt_nxt == CW'(STABLE_CYC)) && (!r_held || i_led != r_pat);
   end

   // Sample register, run counter and accepted-pattern hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sample <= '0;
         r_cnt    <= '0;
         r_pat    <= '0;
         r_held   <= 1'b0;
         r_accept <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_sample <= i_led;
         r_cnt    <= w_cnt_nxt;
         r_accept <= w_fire;
         if (w_fire) begin
            r_pat  <= i_led;
            r_held <= 1'b1;
         end
      end
   end

   assign o_pat    = r_pat;
   assign o_accept = r_accept;

endmodule

// File: rtl/tow_led_monitor.sv
// Receiving end of the tow LED display: filters the bus, decodes accepted
// patterns into rope position / winner / scores and flags protocol errors.
module tow_led_monitor
   import tow_led_monitor_pkg::*;
#(
   parameter int STABLE_CYC = 2,
   parameter int SCORE_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         led_in,
   output logic signed [2:0]  pos,
   output logic               pos_valid,
   output logic               move_strb,
   output logic               win_l,
   output logic               win_r,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               err,
   output logic [1:0]         err_code
);

   logic [6:0]         w_acc_pat;
   logic               w_accept;
   pat_t               w_dec;
   logic [3:0]         w_diff;
   logic               w_step_ok;
   logic               w_pos_ok;

   state_e             r_state, w_state_nxt;
   logic [2:0]         r_pos, w_pos_nxt;
   logic               r_pos_valid, w_pos_valid_nxt;
   logic               r_move, w_move_nxt;
   logic               r_win_l, w_win_l_nxt;
   logic               r_win_r, w_win_r_nxt;
   logic [SCORE_W-1:0] r_score_l, w_score_l_nxt;
   logic [SCORE_W-1:0] r_score_r, w_score_r_nxt;
   logic               r_err, w_err_nxt;
   err_code_e          r_code, w_code_nxt;

   tow_led_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
      .clk      (clk),
      .rst      (rst),
      .i_led    (led_in),
      .o_pat    (w_acc_pat),
      .o_accept (w_accept)
   );

   assign w_dec     = decode_led(w_acc_pat);
   // Jump size on sign-extended positions; legal steps are -1, 0, +1.
   assign w_diff    = {w_dec.pos[2], w_dec.pos} - {r_pos[2], r_pos};
   assign w_step_ok = (w_diff == 4'b0000) || (w_diff == 4'b0001) || (w_diff == 4'b1111);
   assign w_pos_ok  = r_pos_valid ? w_step_ok : (w_dec.pos == POS_N);

   // Next game state from the current state and the freshly accepted pattern.
   always_comb begin
      w_state_nxt     = r_state;
      w_pos_nxt       = r_pos;
      w_pos_valid_nxt = r_pos_valid;
      w_move_nxt      = 1'b0;
      w_win_l_nxt     = r_win_l;
      w_win_r_nxt     = r_win_r;
      w_score_l_nxt   = r_score_l;
      w_score_r_nxt   = r_score_r;
      w_err_nxt       = r_err;
      w_code_nxt      = r_code;

      if (w_accept) begin
         if (w_dec.kind == PK_ALLON) begin
            // Game reset wins over every other rule; scores survive it.
            w_state_nxt     = ST_GRST;
            w_pos_nxt       = POS_N;
            w_pos_valid_nxt = 1'b0;
            w_win_l_nxt     = 1'b0;
            w_win_r_nxt     = 1'b0;
            w_err_nxt       = 1'b0;
            w_code_nxt      = ERR_NONE;
         end else begin
            case (r_state)
               ST_GRST, ST_DARK, ST_POS: begin
                  case (w_dec.kind)
                     PK_DARK: w_state_nxt = ST_DARK;
                     PK_POS: begin
                        if (w_pos_ok) begin
                           w_state_nxt     = ST_POS;
                           w_pos_nxt       = w_dec.pos;
                           w_pos_valid_nxt = 1'b1;
                           w_move_nxt      = (w_dec.pos != r_pos);
                        end else begin
                           w_state_nxt = ST_ERR;
                           w_err_nxt   = 1'b1;
                           w_code_nxt  = ERR_JUMP;
                        end
                     end
                     PK_WL: begin
                        if (r_pos_valid && r_pos == POS_L3) begin
                           w_state_nxt   = ST_WIN;
                           w_win_l_nxt   = 1'b1;
                           w_score_l_nxt = (&r_score_l) ? r_score_l : r_score_l + SCORE_W'(1);
                        end else begin
                           w_state_nxt = ST_ERR;
                           w_err_nxt   = 1'b1;
                           w_code_nxt  = ERR_WIN;
                        end
                     end
                     PK_WR: begin
                        if (r_pos_valid && r_pos == POS_R3) begin
                           w_state_nxt   = ST_WIN;
                           w_win_r_nxt   = 1'b1;
                           w_score_r_nxt = (&r_score_r) ? r_score_r : r_score_r + SCORE_W'(1);
                        end else begin
                           w_state_nxt = ST_ERR;
                           w_err_nxt   = 1'b1;
                           w_code_nxt  = ERR_WIN;
                        end
                     end
                     default: begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_UNKNOWN;
                     end
                  endcase
               end
               ST_WIN: begin
                  // Blinking between dark and the same win pattern is not a new win.
                  if (!(w_dec.kind == PK_DARK ||
                        (w_dec.kind == PK_WL && r_win_l) ||
                        (w_dec.kind == PK_WR && r_win_r))) begin
                     w_state_nxt = ST_ERR;
                     w_err_nxt   = 1'b1;
                     w_code_nxt  = (w_dec.kind == PK_BAD) ? ERR_UNKNOWN : ERR_JUMP;
                  end
               end
               default: ;  // IDLE and ERR ignore everything except ALLON
            endcase
         end
      end
   end

   // Game state registers; a hardware reset also clears the scores.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_pos       <= POS_N;
         r_pos_valid <= 1'b0;
         r_move      <= 1'b0;
         r_win_l     <= 1'b0;
         r_win_r     <= 1'b0;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_err       <= 1'b0;
         r_code      <= ERR_NONE;
      end else begin
         r_state     <= w_state_nxt;
         r_pos       <= w_pos_nxt;
         r_pos_valid <= w_pos_valid_nxt;
         r_move      <= w_move_nxt;
         r_win_l     <= w_win_l_nxt;
         r_win_r     <= w_win_r_nxt;
         r_score_l   <= w_score_l_nxt;
         r_score_r   <= w_score_r_nxt;
         r_err       <= w_err_nxt;
         r_code      <= w_code_nxt;
      end
   end

   assign pos       = r_pos;
   assign pos_valid = r_pos_valid;
   assign move_strb = r_move;
   assign win_l     = r_win_l;
   assign win_r     = r_win_r;
   assign score_l   = r_score_l;
   assign score_r   = r_score_r;
   assign err       = r_err;
   assign err_code  = r_code;

endmodule

// File: tb/tb_tow_led_monitor.sv
// Directed bench for tow_led_monitor: stimulus pushes hand-computed expected
// states into a scoreboard queue; a monitor process pops and compares them.
module tb_tow_led_monitor;

   logic              clk = 1'b0;
   logic              rst;
   logic [6:0]        led_in;
   logic signed [2:0] pos;
   logic              pos_valid, move_strb, win_l, win_r, err;
   logic [3:0]        score_l, score_r;
   logic [1:0]        err_code;

   typedef struct {
      string      name;
      logic [2:0] pos;
      logic       pos_valid;
      logic       win_l;
      logic       win_r;
      logic [3:0] score_l;
      logic [3:0] score_r;
      logic       err;
      logic [1:0] code;
      int         strobes;
   } exp_t;

   exp_t sb_q[$];
   event ev_check;
   int   n_checks   = 0;
   int   n_pass     = 0;
   int   strobe_cnt = 0;

   tow_led_monitor #(.STABLE_CYC(2), .SCORE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .led_in    (led_in),
      .pos       (pos),
      .pos_valid (pos_valid),
      .move_strb (move_strb),
      .win_l     (win_l),
      .win_r     (win_r),
      .score_l   (score_l),
      .score_r   (score_r),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   // Count strobe pulses just after each active edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (move_strb === 1'b1) strobe_cnt++;
   end

   // Scoreboard monitor: compare every queued expectation against the DUT.
   initial forever begin
      @(ev_check);
      while (sb_q.size() != 0) begin
         exp_t x;
         x = sb_q.pop_front();
         n_checks++;
         if (pos === $signed(x.pos) && pos_valid === x.pos_valid && win_l === x.win_l &&
             win_r === x.win_r && score_l === x.score_l && score_r === x.score_r &&
             err === x.err && err_code === x.code && strobe_cnt == x.strobes)
            n_pass++;
         else
            $display("FAIL %s: got pos=%0d v=%0b wl=%0b wr=%0b sl=%0d sr=%0d err=%0b code=%0d strb=%0d, expected pos=%0d v=%0b wl=%0b wr=%0b sl=%0d sr=%0d err=%0b code=%0d strb=%0d",
                     x.name, pos, pos_valid, win_l, win_r, score_l, score_r, err, err_code, strobe_cnt,
                     $signed(x.pos), x.pos_valid, x.win_l, x.win_r, x.score_l, x.score_r, x.err, x.code, x.strobes);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic expect_state(input string name, input int p, input bit v, input bit wl,
                               input bit wr, input int sl, input int sr, input bit e,
                               input int c, input int st);
      exp_t x;
      x.name = name;  x.pos = 3'(p);  x.pos_valid = v;
      x.win_l = wl;   x.win_r = wr;
      x.score_l = 4'(sl);  x.score_r = 4'(sr);
      x.err = e;  x.code = 2'(c);  x.strobes = st;
      sb_q.push_back(x);
      ->ev_check;
   endtask

   // Drive a pattern and hold it long enough for the filter and FSM to act.
   task automatic apply(input logic [6:0] p, input int hold = 4);
      @(negedge clk);
      led_in = p;
      repeat (hold) @(negedge clk);
   endtask

   initial begin
      rst    = 1'b0;
      led_in = 7'b0000100;
      #2;
      expect_state("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      expect_state("idle_ignores", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // T1
      apply(7'b1111111);  expect_state("grst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(7'b0000000);  expect_state("dark", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(7'b0001000);  expect_state("first_n", 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // T2, including the exact accept latency
      @(negedge clk);
      led_in = 7'b0010000;
      repeat (2) @(negedge clk);
      expect_state("latency_before", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      expect_state("latency_after", -1, 1, 0, 0, 0, 0, 0, 0, 1);
      apply(7'b0000000);  expect_state("dark_hold", -1, 1, 0, 0, 0, 0, 0, 0, 1);
      apply(7'b0010000);  expect_state("blink_nostrb", -1, 1, 0, 0, 0, 0, 0, 0, 1);
      apply(7'b0100000);  expect_state("to_l2", -2, 1, 0, 0, 0, 0, 0, 0, 2);

      // T6 glitch: one cycle of another pattern must not be accepted
      @(negedge clk);
      led_in = 7'b1000000;
      @(negedge clk);
      led_in = 7'b0100000;
      repeat (4) @(negedge clk);
      expect_state("glitch", -2, 1, 0, 0, 0, 0, 0, 0, 2);

      // T3
      apply(7'b1000000);  expect_state("to_l3", -3, 1, 0, 0, 0, 0, 0, 0, 3);
      apply(7'b1110000);  expect_state("win_l", -3, 1, 1, 0, 1, 0, 0, 0, 3);
      for (int i = 0; i < 3; i++) begin
         apply(7'b0000000);
         apply(7'b1110000);
      end
      expect_state("win_blink", -3, 1, 1, 0, 1, 0, 0, 0, 3);

      // T4
      apply(7'b1111111);  expect_state("grst_keep_score", 0, 0, 0, 0, 1, 0, 0, 0, 3);
      apply(7'b0001000);  expect_state("n_again", 0, 1, 0, 0, 1, 0, 0, 0, 3);
      apply(7'b0010000);  expect_state("to_l1", -1, 1, 0, 0, 1, 0, 0, 0, 4);
      apply(7'b1000000);  expect_state("jump_err", -1, 1, 0, 0, 1, 0, 1, 2, 4);
      apply(7'b0001000);  expect_state("err_frozen", -1, 1, 0, 0, 1, 0, 1, 2, 4);
      apply(7'b1111111);  expect_state("err_clear", 0, 0, 0, 0, 1, 0, 0, 0, 4);

      // T5
      apply(7'b0001000);
      apply(7'b0000111);  expect_state("bad_win", 0, 1, 0, 0, 1, 0, 1, 3, 4);
      apply(7'b1111111);
      apply(7'b0001000);
      apply(7'b0110000);  expect_state("unknown", 0, 1, 0, 0, 1, 0, 1, 1, 4);
      apply(7'b1111111);  expect_state("clear2", 0, 0, 0, 0, 1, 0, 0, 0, 4);

      // Right-side win, then a wrong pattern out of WIN
      apply(7'b0001000);
      apply(7'b0000100);
      apply(7'b0000010);
      apply(7'b0000001);  expect_state("to_r3", 3, 1, 0, 0, 1, 0, 0, 0, 7);
      apply(7'b0000111);  expect_state("win_r", 3, 1, 0, 1, 1, 1, 0, 0, 7);
      apply(7'b1110000);  expect_state("win_other", 3, 1, 0, 1, 1, 1, 1, 2, 7);
      apply(7'b1111111);
      apply(7'b0001000);
      apply(7'b0000100);  expect_state("to_r1", 1, 1, 0, 0, 1, 1, 0, 0, 8);

      // Asynchronous reset mid-game clears everything, scores included
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      expect_state("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
